// File: rtl/fifo_stream_reader.sv
// Read-side adapter for sync_fifo: issues pops, absorbs the one-cycle read latency
// and presents entries as a valid/ready stream. Optional: FIFO_READER_BYPASS_EN.
module fifo_stream_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             re,
    input  logic [WIDTH-1:0] r_data,
    input  logic             empty,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state;
    occ_t             state_next;
    logic             inflight;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;

    logic             bypass;
    logic             deq;
    logic             capture;
    logic             capture_skid;
    logic [2:0]       load;

    always_comb begin
        bypass       = 1'b0;
        state_next   = state;
        capture_skid = 1'b0;

`ifdef FIFO_READER_BYPASS_EN
        // Returning pop with nothing buffered is presented straight from r_data.
        bypass = !rst && (state == EMPTY) && inflight;
        valid  = (!rst && (state != EMPTY)) || bypass;
        data   = bypass ? r_data : head;
`else
        valid  = !rst && (state != EMPTY);
        data   = head;
`endif

        // deq covers only buffered beats; a consumed bypass beat is simply not captured.
        deq     = valid && ready && (state != EMPTY);
        capture = inflight && !(bypass && ready);

        // Slot choice uses occupancy after this cycle's dequeue.
        if (capture) begin
            capture_skid = ((state == ONE) && !deq) || ((state == FULL) && deq);
        end

        case ({capture, deq})
            2'b10: begin
                if (state == EMPTY) state_next = ONE;
                else                state_next = FULL;
            end
            2'b01: begin
                if (state == FULL) state_next = ONE;
                else               state_next = EMPTY;
            end
            default: state_next = state;
        endcase

        load = 3'(state) + 3'(inflight) - 3'(valid && ready);
        re   = !rst && !empty && (load < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            state    <= state_next;
            inflight <= re;
            if (deq && (state == FULL)) begin
                head <= skid;
            end
            if (capture) begin
                if (capture_skid) skid <= r_data;
                else              head <= r_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (3'(state) + 3'(inflight) <= 3'd2)
                else $error("fifo_stream_reader: occ + inflight exceeds 2");
        end
    end

endmodule
